// File: rtl/dffram_seq_pkg.sv
// dffram_seq_pkg: shared state encoding, widths and nibble-select constants for the nibble DFFRAM sequencer
package dffram_seq_pkg;
   typedef enum logic [2:0] {IDLE, W_LO, W_HI, R_WAIT, R_HI, R_LO, RESP} seq_state_t;
   localparam int NIB_W = 4;
   localparam int BYTE_W = 2 * NIB_W;
   localparam logic LOHI_WR_LO = 1'b1;
   localparam logic LOHI_RD_HI = 1'b1;
endpackage

// File: rtl/dffram_nibble_rd_seq.sv
// dffram_nibble_rd_seq: two-beat nibble read sequence (high nibble first) producing one byte per request
module dffram_nibble_rd_seq
   import dffram_seq_pkg::*;
#(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = NIB_W,
   parameter int RD_LAT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [AWIDTH-1:0]   addr,
   input  logic [DWIDTH-1:0]   ram_rdata,
   output logic                idle,
   output logic [AWIDTH-1:0]   ram_addr,
   output logic                ram_lohi,
   output logic                rvalid,
   output logic [2*DWIDTH-1:0] rdata
);
   seq_state_t state, state_nx;
   logic [DWIDTH-1:0] hi_nib;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? (RD_LAT > 0 ? R_WAIT : R_HI) : IDLE;
         R_WAIT:  state_nx = R_HI;
         R_HI:    state_nx = R_LO;
         R_LO:    state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end
   // A buffered RAM shows the select one cycle late, so lohi drops on entry to R_HI rather than R_LO
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ram_addr <= '0;
         ram_lohi <= 1'b0;
         hi_nib   <= '0;
         rdata    <= '0;
      end else begin
         state    <= state_nx;
         if (state == IDLE && start) ram_addr <= addr;
         ram_lohi <= (state_nx == R_WAIT || (state_nx == R_HI && RD_LAT == 0)) ? LOHI_RD_HI : ~LOHI_RD_HI;
         if (state == R_HI) hi_nib <= ram_rdata;
         if (state == R_LO) rdata <= {hi_nib, ram_rdata};
      end
   end
   assign idle   = state == IDLE;
   assign rvalid = state == RESP;
endmodule

// File: rtl/dffram_nibble_seq.sv
// dffram_nibble_seq: byte-wide host ports A (read/write) and B (read) sequenced onto the 2R1W nibble DFFRAM
module dffram_nibble_seq
   import dffram_seq_pkg::*;
#(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = NIB_W,
   parameter int RD_LAT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic                a_we,
   input  logic [AWIDTH-1:0]   a_addr,
   input  logic [2*DWIDTH-1:0] a_wdata,
   output logic                a_rvalid,
   output logic [2*DWIDTH-1:0] a_rdata,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [AWIDTH-1:0]   b_addr,
   output logic                b_rvalid,
   output logic [2*DWIDTH-1:0] b_rdata,
   output logic [AWIDTH-1:0]   ram_addr_a,
   output logic [DWIDTH-1:0]   ram_wdata_a,
   output logic                ram_lohi_a,
   output logic                ram_w_en,
   input  logic [DWIDTH-1:0]   ram_rdata_a,
   output logic [AWIDTH-1:0]   ram_addr_b,
   output logic                ram_lohi_b,
   input  logic [DWIDTH-1:0]   ram_rdata_b
);
   seq_state_t w_state, w_state_nx;
   logic a_rd_idle, b_idle, a_acc, hazard, w_lohi, a_rd_lohi;
   logic [AWIDTH-1:0] w_addr, a_rd_addr;
   logic [DWIDTH-1:0] w_hi;
   assign a_ready = a_rd_idle && w_state == IDLE;
   assign a_acc   = a_valid && a_ready;
   assign hazard  = w_state != IDLE && w_addr == b_addr;
   assign b_ready = b_idle && !hazard;
   always_comb w_state_nx = w_state == W_LO ? W_HI : (w_state == IDLE && a_acc && a_we) ? W_LO : IDLE;
   // The low nibble goes out on the accept edge straight from a_wdata; only the high nibble needs holding
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state     <= IDLE;
         w_addr      <= '0;
         w_hi        <= '0;
         ram_w_en    <= 1'b0;
         ram_wdata_a <= '0;
         w_lohi      <= 1'b0;
      end else begin
         w_state     <= w_state_nx;
         if (a_acc && a_we) begin
            w_addr <= a_addr;
            w_hi   <= a_wdata[2*DWIDTH-1:DWIDTH];
         end
         ram_w_en    <= w_state_nx != IDLE;
         ram_wdata_a <= w_state_nx == W_LO ? a_wdata[DWIDTH-1:0] : w_state_nx == W_HI ? w_hi : '0;
         w_lohi      <= w_state_nx == W_LO ? LOHI_WR_LO : ~LOHI_WR_LO;
      end
   end
   // Read and write selects are each zero while their sequence is idle, so OR-ing them is glitch-free
   assign ram_addr_a = w_state != IDLE ? w_addr : a_rd_addr;
   assign ram_lohi_a = w_lohi | a_rd_lohi;
   dffram_nibble_rd_seq #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) u_rd_a (
      .clk       (clk),
      .rst       (rst),
      .start     (a_acc && !a_we),
      .addr      (a_addr),
      .ram_rdata (ram_rdata_a),
      .idle      (a_rd_idle),
      .ram_addr  (a_rd_addr),
      .ram_lohi  (a_rd_lohi),
      .rvalid    (a_rvalid),
      .rdata     (a_rdata)
   );
   dffram_nibble_rd_seq #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) u_rd_b (
      .clk       (clk),
      .rst       (rst),
      .start     (b_valid && b_ready),
      .addr      (b_addr),
      .ram_rdata (ram_rdata_b),
      .idle      (b_idle),
      .ram_addr  (ram_addr_b),
      .ram_lohi  (ram_lohi_b),
      .rvalid    (b_rvalid),
      .rdata     (b_rdata)
   );
endmodule
